// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-slave SRAM: byte/halfword/word access, programmable wait
// states and a two-cycle ERROR response for out-of-range or misaligned transfers.
module ahb_lite_sram_slave #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        H_clk,
  input  logic        H_rstN,
  input  logic        H_sel,
  input  logic [31:0] H_add,
  input  logic        H_WR,
  input  logic [2:0]  H_size,
  input  logic [3:0]  H_burst,
  input  logic [1:0]  H_trans,
  input  logic [31:0] W_data,
  output logic [31:0] R_data,
  output logic        H_readyN,
  output logic        H_rsp
);
  localparam int          NUM_LANES = 4;
  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [2:0] {IDLE_S, WAIT_S, DATA_S, ERR1_S, ERR2_S} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [1:0]           off_q, off_d;
  logic [1:0]           size_q, size_d;
  logic                 wr_q, wr_d;
  logic [31:0]          mem_q [DEPTH_WORDS];
  logic                 sample, valid, err;
  logic [NUM_LANES-1:0] be;

  // Burst type carries no addressing meaning for a single SRAM slave.
  logic unused_burst;
  assign unused_burst = ^H_burst;

  always_comb begin
    sample  = H_sel && (state_q == IDLE_S || state_q == DATA_S || state_q == ERR2_S);
    valid   = H_trans[1];
    err     = valid && (({1'b0, H_add} >= LIMIT) || (H_size > 3'd2) ||
                        (H_size == 3'd1 && H_add[0]) ||
                        (H_size == 3'd2 && H_add[1:0] != 2'd0));
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    wr_d    = wr_q;
    unique case (state_q)
      WAIT_S: begin
        if (cnt_q <= 4'd1) state_d = DATA_S;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ERR1_S: state_d = ERR2_S;
      default: begin
        // IDLE_S, DATA_S, ERR2_S all accept the next address phase.
        state_d = IDLE_S;
        if (sample && err) begin
          state_d = ERR1_S;
        end else if (sample && valid) begin
          state_d = (WAIT_STATES > 0) ? WAIT_S : DATA_S;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = H_add[AW+1:2];
          off_d   = H_add[1:0];
          size_d  = H_size[1:0];
          wr_d    = H_WR;
        end
      end
    endcase
  end

  always_ff @(posedge H_clk or negedge H_rstN) begin
    if (!H_rstN) begin
      state_q <= IDLE_S;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    unique case (size_q)
      2'd0:    be = 4'b0001 << off_q;
      2'd1:    be = 4'b0011 << off_q;
      default: be = 4'b1111;
    endcase
  end

  // Storage is deliberately not reset; reset only returns the FSM to IDLE_S,
  // which also cancels any write still waiting for its data phase.
  always_ff @(posedge H_clk) begin
    if (state_q == DATA_S && wr_q) begin
      for (int b = 0; b < NUM_LANES; b++)
        if (be[b]) mem_q[idx_q][8*b +: 8] <= W_data[8*b +: 8];
    end
  end

  assign H_readyN = (state_q != WAIT_S) && (state_q != ERR1_S);
  assign H_rsp    = (state_q == ERR1_S) || (state_q == ERR2_S);
  assign R_data   = (state_q == DATA_S && !wr_q) ? mem_q[idx_q] : '0;

endmodule
